// File: rtl/multich_dds_gen_if.sv
// Configuration register port of multich_dds_gen: valid/ready write of one field
// of one channel's shadow register set.
interface multich_dds_gen_if #(
  parameter int CW = 1,
  parameter int PW = 32
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [1:0]    cfg_addr;
  logic [PW-1:0] cfg_data;

  modport master (output cfg_valid, cfg_ch, cfg_addr, cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_addr, cfg_data, output cfg_ready);
endinterface

// File: rtl/multich_dds_gen.sv
// Multi-channel DDS generator: per-channel phase accumulator, offset, gain and wave mode,
// shadow config committed at phase wrap. Optional phase resync port under `DDS_PHASE_SYNC_EN.
module multich_dds_gen #(
  parameter int CH = 2,
  parameter int DW = 12,
  parameter int PW = 32,
  parameter int AW = 8
) (
  input  logic               clk,
  input  logic               rst,
  multich_dds_gen_if.slave   cfg,
  input  logic               run,
  input  logic               sample_tick,
`ifdef DDS_PHASE_SYNC_EN
  input  logic               sync,
`endif
  output logic [CH-1:0]      pending,
  output logic [CH*DW-1:0]   wave_out,
  output logic               wave_valid
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};

  logic sync_i;
`ifdef DDS_PHASE_SYNC_EN
  assign sync_i = sync;
`else
  assign sync_i = 1'b0;
`endif

  logic ready;
  assign cfg.cfg_ready = ready;

  logic [PW-1:0] acc [CH];
  logic [PW-1:0] freq [CH];
  logic [PW-1:0] phase [CH];
  logic [AW-1:0] amp [CH];
  logic [1:0]    mode [CH];
  logic [PW-1:0] sh_freq [CH];
  logic [PW-1:0] sh_phase [CH];
  logic [AW-1:0] sh_amp [CH];
  logic [1:0]    sh_mode [CH];

  logic [PW:0]   sum [CH];
  logic [PW-1:0] acc_nxt [CH];
  logic [PW-1:0] ph_sum [CH];
  logic [DW-1:0] raw_nxt [CH];
  logic [AW-1:0] amp_eff [CH];
  logic [CH-1:0] commit;
  logic [CH-1:0] wr_hit;
  logic          adv;

  logic [DW-1:0] raw_p1 [CH];
  logic [AW-1:0] amp_p1 [CH];
  logic          vld_p1;

  function automatic logic [DW-1:0] wave_raw(input logic [PW-1:0] p, input logic [1:0] m);
    logic [DW-1:0] u;
    u = p[PW-1 -: DW];
    case (m)
      2'd0:    wave_raw = {DW{u[DW-1]}};
      2'd1:    wave_raw = u;
      2'd2:    wave_raw = u[DW-1] ? ~{u[DW-2:0], 1'b0} : {u[DW-2:0], 1'b0};
      default: wave_raw = MID;
    endcase
  endfunction

  // Gain is amp/2^AW about midscale; the result always stays in range, so no clamp.
  function automatic logic [DW-1:0] scale(input logic [DW-1:0] raw, input logic [AW-1:0] a);
    logic signed [DW:0]      s;
    logic signed [DW+AW+1:0] prod;
    logic signed [DW+AW+1:0] shifted;
    s       = $signed({1'b0, raw}) - $signed({1'b0, MID});
    prod    = s * $signed({1'b0, a});
    shifted = prod >>> AW;
    scale   = MID + shifted[DW-1:0];
  endfunction

  // Stage 0: accumulate, decide commits, form the raw sample from post-increment phase
  always_comb begin
    adv    = run & sample_tick;
    commit = '0;
    wr_hit = '0;
    for (int k = 0; k < CH; k++) begin
      sum[k]     = {1'b0, acc[k]} + {1'b0, freq[k]};
      commit[k]  = pending[k] & ((adv & sum[k][PW]) | ~run | (freq[k] == '0) | sync_i);
      wr_hit[k]  = cfg.cfg_valid & ready & (cfg.cfg_ch == CW'(k));
      acc_nxt[k] = sync_i ? '0 : (adv ? sum[k][PW-1:0] : acc[k]);
      ph_sum[k]  = acc_nxt[k] + (commit[k] ? sh_phase[k] : phase[k]);
      raw_nxt[k] = wave_raw(ph_sum[k], commit[k] ? sh_mode[k] : mode[k]);
      amp_eff[k] = commit[k] ? sh_amp[k] : amp[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready      <= 1'b0;
      pending    <= '0;
      vld_p1     <= 1'b0;
      wave_valid <= 1'b0;
      for (int k = 0; k < CH; k++) begin
        acc[k]      <= '0;
        freq[k]     <= '0;
        phase[k]    <= '0;
        amp[k]      <= '0;
        mode[k]     <= '0;
        sh_freq[k]  <= '0;
        sh_phase[k] <= '0;
        sh_amp[k]   <= '0;
        sh_mode[k]  <= '0;
        wave_out[k*DW +: DW] <= MID;
      end
    end else begin
      ready      <= 1'b1;
      vld_p1     <= sample_tick;
      wave_valid <= vld_p1;
      for (int k = 0; k < CH; k++) begin
        acc[k] <= acc_nxt[k];
        if (commit[k]) begin
          freq[k]  <= sh_freq[k];
          phase[k] <= sh_phase[k];
          amp[k]   <= sh_amp[k];
          mode[k]  <= sh_mode[k];
        end
        // A write landing with a commit goes to the shadow and re-arms pending.
        if (wr_hit[k]) begin
          case (cfg.cfg_addr)
            2'd0:    sh_freq[k]  <= cfg.cfg_data;
            2'd1:    sh_phase[k] <= cfg.cfg_data;
            2'd2:    sh_amp[k]   <= cfg.cfg_data[AW-1:0];
            default: sh_mode[k]  <= cfg.cfg_data[1:0];
          endcase
        end
        pending[k] <= wr_hit[k] | (pending[k] & ~commit[k]);
        // Stage 2: scaled output lanes
        if (vld_p1) wave_out[k*DW +: DW] <= scale(raw_p1[k], amp_p1[k]);
      end
    end
  end

  // Stage 1: raw sample and its gain
  always_ff @(posedge clk) begin
    for (int k = 0; k < CH; k++) begin
      raw_p1[k] <= raw_nxt[k];
      amp_p1[k] <= amp_eff[k];
    end
  end
endmodule

// File: tb/tb_multich_dds_gen.sv
// Scoreboard bench for multich_dds_gen: an arithmetic reference model predicts every
// strobe's lanes and arrival cycle; a negedge monitor pops and compares.
module tb_multich_dds_gen;
  localparam int CH = 3;
  localparam int DW = 12;
  localparam int PW = 32;
  localparam int AW = 8;
  localparam int CW = 2;
  localparam bit [63:0] MASK = (64'd1 << PW) - 1;
  localparam int MIDV = 1 << (DW - 1);

  logic clk = 1'b0;
  logic rst, run, sample_tick, sync;
  logic [CH-1:0] pending;
  logic [CH*DW-1:0] wave_out;
  logic wave_valid;

  multich_dds_gen_if #(.CW(CW), .PW(PW)) cfg_bus ();

  multich_dds_gen #(.CH(CH), .DW(DW), .PW(PW), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .cfg(cfg_bus),
    .run(run),
    .sample_tick(sample_tick),
`ifdef DDS_PHASE_SYNC_EN
    .sync(sync),
`endif
    .pending(pending),
    .wave_out(wave_out),
    .wave_valid(wave_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    logic [CH*DW-1:0] data;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit [63:0] m_acc [CH];
  bit [63:0] m_freq [CH];
  bit [63:0] m_ph [CH];
  bit [63:0] s_freq [CH];
  bit [63:0] s_ph [CH];
  int m_amp [CH];
  int m_mode [CH];
  int s_amp [CH];
  int s_mode [CH];
  bit [CH-1:0] m_pend;
  bit m_ready;

  function automatic int sample_of(input bit [63:0] acc, input bit [63:0] ph, input int a, input int md);
    bit [63:0] p;
    int u, raw, prod, d, qt;
    p = (acc + ph) & MASK;
    u = int'(p >> (PW - DW));
    case (md)
      0: raw = (u >= MIDV) ? (2 * MIDV - 1) : 0;
      1: raw = u;
      2: raw = (u < MIDV) ? 2 * u : (4 * MIDV - 1) - 2 * u;
      default: raw = MIDV;
    endcase
    prod = (raw - MIDV) * a;
    d = 1 << AW;
    qt = prod / d;
    if (prod < 0 && qt * d != prod) qt = qt - 1;
    return MIDV + qt;
  endfunction

  task automatic model_step(input bit r, input bit v, input int ch, input int addr,
                            input bit [63:0] data, input bit rn, input bit tk, input bit sy);
    bit [CH*DW-1:0] vec;
    bit [63:0] sm;
    bit cm, wr;
    int s;
    if (r) begin
      for (int k = 0; k < CH; k++) begin
        m_acc[k] = 0; m_freq[k] = 0; m_ph[k] = 0; m_amp[k] = 0; m_mode[k] = 0;
        s_freq[k] = 0; s_ph[k] = 0; s_amp[k] = 0; s_mode[k] = 0;
      end
      m_pend = '0;
      m_ready = 1'b0;
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      return;
    end
    wr = v && m_ready;
    vec = '0;
    for (int k = 0; k < CH; k++) begin
      sm = m_acc[k] + m_freq[k];
      cm = m_pend[k] && ((rn && tk && sm > MASK) || !rn || m_freq[k] == 0 || sy);
      if (sy) m_acc[k] = 0;
      else if (rn && tk) m_acc[k] = sm & MASK;
      if (cm) begin
        m_freq[k] = s_freq[k]; m_ph[k] = s_ph[k]; m_amp[k] = s_amp[k]; m_mode[k] = s_mode[k];
        m_pend[k] = 1'b0;
      end
      s = sample_of(m_acc[k], m_ph[k], m_amp[k], m_mode[k]);
      vec[k*DW +: DW] = s[DW-1:0];
      if (wr && ch == k) begin
        case (addr)
          0: s_freq[k] = data & MASK;
          1: s_ph[k]   = data & MASK;
          2: s_amp[k]  = int'(data % (64'd1 << AW));
          default: s_mode[k] = int'(data % 4);
        endcase
        m_pend[k] = 1'b1;
      end
    end
    if (tk) q.push_back('{due: cyc + 2, data: vec});
    m_ready = 1'b1;
  endtask

  task automatic drive(input bit r, input bit v, input int ch, input int addr,
                       input bit [63:0] data, input bit rn, input bit tk, input bit sy);
    rst = r;
    cfg_bus.cfg_valid = v;
    cfg_bus.cfg_ch = CW'(ch);
    cfg_bus.cfg_addr = 2'(addr);
    cfg_bus.cfg_data = PW'(data);
    run = rn;
    sample_tick = tk;
    sync = sy;
    model_step(r, v, ch, addr, data & MASK, rn, tk, sync);
    @(posedge clk);
    #1;
    n_tests++;
    if (pending !== m_pend) begin
      n_fail++;
      $display("FAIL pending cyc=%0d got %b want %b", cyc, pending, m_pend);
    end
    n_tests++;
    if (cfg_bus.cfg_ready !== m_ready) begin
      n_fail++;
      $display("FAIL cfg_ready cyc=%0d got %b want %b", cyc, cfg_bus.cfg_ready, m_ready);
    end
  endtask

  task automatic wr(input int ch, input int addr, input bit [63:0] data, input bit rn, input bit tk);
    drive(1'b0, 1'b1, ch, addr, data, rn, tk, 1'b0);
  endtask

  task automatic idle(input int n, input bit rn, input bit tk);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 64'd0, rn, tk, 1'b0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (wave_valid === 1'b1) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe cyc=%0d got wave_out %h want no strobe", cyc, wave_out);
      end else begin
        e = q.pop_front();
        if (wave_out !== e.data || e.due != cyc) begin
          n_fail++;
          $display("FAIL sample cyc=%0d got %h want %h (due cyc %0d)", cyc, wave_out, e.data, e.due);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_strobe cyc=%0d got none want %h", cyc, q[0].data);
      void'(q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; sample_tick = 1'b0; sync = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_ch = '0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_data = '0;

    // reset state
    repeat (3) drive(1'b1, 1'b0, 0, 0, 64'd0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (wave_out !== {CH{12'h800}}) begin
      n_fail++;
      $display("FAIL reset_lanes got %h want %h", wave_out, {CH{12'h800}});
    end
    n_tests++;
    if (wave_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b want 0", wave_valid);
    end
    idle(1, 1'b0, 1'b0);

    // single-channel saw, tick every cycle, through a full wrap
    wr(0, 0, 64'h0100_0000, 1'b0, 1'b0);
    wr(0, 2, 64'hFF, 1'b0, 1'b0);
    wr(0, 3, 64'd1, 1'b0, 1'b0);
    idle(300, 1'b1, 1'b1);

    // commit at wrap, and writes colliding with commits
    wr(1, 0, 64'h1000_0000, 1'b0, 1'b0);
    wr(1, 2, 64'hFF, 1'b0, 1'b0);
    wr(1, 3, 64'd1, 1'b0, 1'b0);
    idle(20, 1'b1, 1'b1);
    wr(1, 0, 64'h2000_0000, 1'b1, 1'b1);
    n_tests++;
    if (pending[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_after_write got %b want 1", pending[1]);
    end
    idle(40, 1'b1, 1'b1);
    for (int i = 0; i < 24; i++) wr(1, 0, (i % 2) ? 64'h3000_0000 : 64'h2000_0000, 1'b1, 1'b1);
    idle(20, 1'b1, 1'b1);

    // wave modes, then frozen run=0 ticks
    wr(0, 1, 64'h4000_0000, 1'b1, 1'b1);
    wr(0, 3, 64'd2, 1'b1, 1'b1);
    wr(1, 3, 64'd0, 1'b1, 1'b1);
    wr(1, 2, 64'h80, 1'b1, 1'b1);
    wr(2, 3, 64'd3, 1'b1, 1'b1);
    wr(2, 2, 64'hFF, 1'b1, 1'b1);
    idle(100, 1'b1, 1'b1);
    idle(10, 1'b0, 1'b1);
    wr(0, 2, 64'h40, 1'b0, 1'b1);
    idle(5, 1'b0, 1'b1);

    // out-of-range channel, reset mid-stream
    wr(3, 0, 64'h1234_5678, 1'b1, 1'b1);
    idle(5, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 0, 0, 64'd0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 64'd0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b1);

`ifdef DDS_PHASE_SYNC_EN
    wr(0, 0, 64'h0100_0000, 1'b1, 1'b1);
    wr(1, 0, 64'h0300_0000, 1'b1, 1'b1);
    wr(0, 3, 64'd1, 1'b1, 1'b1);
    wr(1, 3, 64'd1, 1'b1, 1'b1);
    wr(0, 2, 64'hFF, 1'b1, 1'b1);
    wr(1, 2, 64'hFF, 1'b1, 1'b1);
    idle(30, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 0, 0, 64'd0, 1'b1, 1'b1, 1'b1);
    idle(10, 1'b1, 1'b1);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, v, rn, tk, sy;
      r  = ($urandom % 200) == 0;
      v  = ($urandom % 4) == 0;
      rn = ($urandom % 8) != 0;
      tk = ($urandom % 4) != 0;
      sy = 1'b0;
`ifdef DDS_PHASE_SYNC_EN
      sy = ($urandom % 40) == 0;
`endif
      drive(r, v, int'($urandom % (CH + 1)), int'($urandom % 4), 64'($urandom), rn, tk, sy);
    end

    idle(4, 1'b1, 1'b0);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d outstanding want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
